// File: rtl/cpu_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_mem_stage
//  Purpose  : Pipeline memory stage: ALU pass-through, or stalled data-bus
//             write/read sequencing with writeback and return-address branch.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_mem_stage #(
    parameter int ADDR_W = 32,
    parameter int PCB_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [PCB_W-1:0]  pipeline_control_bits_i,
    input  logic [3:0]        register0_write_index_i,
    input  logic [3:0]        register1_write_index_i,
    input  logic [31:0]       reg0_result_i,
    input  logic [31:0]       reg1_result_i,
    input  logic [ADDR_W-1:0] memory_address_i,
    input  logic [31:0]       mem_result_i,
    output logic              stall_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic              dmem_ack_i,
    input  logic [31:0]       dmem_rdata_i,
    output logic              register_wea_o,
    output logic              register_web_o,
    output logic [3:0]        register0_write_index_o,
    output logic [3:0]        register1_write_index_o,
    output logic [31:0]       reg0_result_o,
    output logic [31:0]       reg1_result_o,
    output logic              branch_flag_o,
    output logic [31:0]       branch_target_o
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WRITE = 2'd1;
    localparam logic [1:0] c_READ  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic              w_mem_op;
    logic              w_finish;
    logic              w_load_ret;

    logic              r_wa;
    logic              r_wb;
    logic              r_mr;
    logic              r_ret;
    logic [3:0]        r_idx0;
    logic [3:0]        r_idx1;
    logic [31:0]       r_reg0;
    logic [31:0]       r_reg1;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    assign w_mem_op   = pipeline_control_bits_i[2] | pipeline_control_bits_i[3];
    // The last bus transaction of an op completes here; writeback is staged for DONE.
    assign w_finish   = dmem_ack_i & (((r_state == c_WRITE) & ~r_mr) | (r_state == c_READ));
    assign w_load_ret = (r_state == c_READ) & r_ret;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_mem_op) begin
                    w_next = pipeline_control_bits_i[2] ? c_WRITE : c_READ;
                end
            end
            c_WRITE: begin
                if (dmem_ack_i) begin
                    w_next = r_mr ? c_READ : c_DONE;
                end
            end
            c_READ: begin
                if (dmem_ack_i) begin
                    w_next = c_DONE;
                end
            end
            c_DONE:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        stall_o      = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_addr_o  = '0;
        dmem_wdata_o = '0;
        case (r_state)
            c_IDLE:  stall_o = w_mem_op;
            c_WRITE: begin
                stall_o      = 1'b1;
                dmem_req_o   = 1'b1;
                dmem_we_o    = 1'b1;
                dmem_addr_o  = r_addr;
                dmem_wdata_o = r_wdata;
            end
            c_READ: begin
                stall_o     = 1'b1;
                dmem_req_o  = 1'b1;
                dmem_addr_o = r_addr;
            end
            default: stall_o = 1'b0;
        endcase
    end

    // Operands are captured only when a memory op is accepted in IDLE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wa    <= 1'b0;
            r_wb    <= 1'b0;
            r_mr    <= 1'b0;
            r_ret   <= 1'b0;
            r_idx0  <= '0;
            r_idx1  <= '0;
            r_reg0  <= '0;
            r_reg1  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if ((r_state == c_IDLE) && w_mem_op) begin
            r_wa    <= pipeline_control_bits_i[0];
            r_wb    <= pipeline_control_bits_i[1];
            r_mr    <= pipeline_control_bits_i[3];
            r_ret   <= pipeline_control_bits_i[4];
            r_idx0  <= register0_write_index_i;
            r_idx1  <= register1_write_index_i;
            r_reg0  <= reg0_result_i;
            r_reg1  <= reg1_result_i;
            r_addr  <= memory_address_i;
            r_wdata <= mem_result_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            register_wea_o          <= 1'b0;
            register_web_o          <= 1'b0;
            register0_write_index_o <= '0;
            register1_write_index_o <= '0;
            reg0_result_o           <= '0;
            reg1_result_o           <= '0;
            branch_flag_o           <= 1'b0;
            branch_target_o         <= '0;
        end else begin
            // Enables and branch are one-cycle pulses unless reloaded below.
            register_wea_o  <= 1'b0;
            register_web_o  <= 1'b0;
            branch_flag_o   <= 1'b0;
            branch_target_o <= '0;
            if ((r_state == c_IDLE) && !w_mem_op) begin
                register_wea_o          <= pipeline_control_bits_i[0];
                register_web_o          <= pipeline_control_bits_i[1];
                register0_write_index_o <= register0_write_index_i;
                register1_write_index_o <= register1_write_index_i;
                reg0_result_o           <= reg0_result_i;
                reg1_result_o           <= reg1_result_i;
            end else if (w_finish) begin
                register_wea_o          <= r_wa;
                register_web_o          <= r_wb;
                register0_write_index_o <= r_idx0;
                register1_write_index_o <= r_idx1;
                reg1_result_o           <= r_reg1;
                if ((r_state == c_READ) && !r_ret) begin
                    reg0_result_o <= dmem_rdata_i;
                end else begin
                    reg0_result_o <= r_reg0;
                end
                branch_flag_o   <= w_load_ret;
                branch_target_o <= w_load_ret ? dmem_rdata_i : 32'h0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_mem_stage
//  Purpose  : Scoreboard bench for cpu_mem_stage with a bus responder model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  pcb;
    logic [3:0]  i0_in, i1_in;
    logic [31:0] r0_in, r1_in, addr_in, md_in;
    logic        stall_o, dmem_req_o, dmem_we_o, dmem_ack_i;
    logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
    logic        wea, web, bf;
    logic [3:0]  i0_o, i1_o;
    logic [31:0] r0_o, r1_o, bt;

    cpu_mem_stage #(.ADDR_W(32), .PCB_W(5)) dut (
        .clk_i(clk), .rst_i(rst),
        .pipeline_control_bits_i(pcb),
        .register0_write_index_i(i0_in), .register1_write_index_i(i1_in),
        .reg0_result_i(r0_in), .reg1_result_i(r1_in),
        .memory_address_i(addr_in), .mem_result_i(md_in),
        .stall_o(stall_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .register_wea_o(wea), .register_web_o(web),
        .register0_write_index_o(i0_o), .register1_write_index_o(i1_o),
        .reg0_result_o(r0_o), .reg1_result_o(r1_o),
        .branch_flag_o(bf), .branch_target_o(bt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
    } bus_t;

    typedef struct {
        logic        wea, web, bf;
        logic [3:0]  i0, i1;
        logic [31:0] r0, r1, bt;
    } wb_t;

    typedef struct {
        logic [4:0]  pcb;
        logic [3:0]  i0, i1;
        logic [31:0] r0, r1, addr, wd, rdata;
        int          d0, d1;
    } op_t;

    bus_t busq[$];
    wb_t  wbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic nop();
        pcb = '0; i0_in = '0; i1_in = '0; r0_in = '0; r1_in = '0; addr_in = '0; md_in = '0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctrl"}, {58'h0, stall_o, dmem_req_o, dmem_we_o, wea, web, bf}, 64'h0);
        chk({tag, "_addr"}, dmem_addr_o, 0);
        chk({tag, "_wdata"}, dmem_wdata_o, 0);
        chk({tag, "_idx"}, {i0_o, i1_o}, 0);
        chk({tag, "_r0"}, r0_o, 0);
        chk({tag, "_r1"}, r1_o, 0);
        chk({tag, "_bt"}, bt, 0);
    endtask

    function automatic op_t mk(input logic [4:0] p, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] x0, input logic [31:0] v0,
                               input logic [3:0] x1, input logic [31:0] v1,
                               input logic [31:0] rd, input int d0, input int d1);
        op_t o;
        o.pcb = p; o.addr = a; o.wd = wd; o.i0 = x0; o.r0 = v0; o.i1 = x1; o.r1 = v1;
        o.rdata = rd; o.d0 = d0; o.d1 = d1;
        return o;
    endfunction

    // Called at a negedge while the stage is idle; returns at a later idle negedge.
    task automatic issue(input op_t o);
        logic mw, mr;
        wb_t  e;
        int   exp_n, n, rd_delay;
        mw = o.pcb[2];
        mr = o.pcb[3];
        pcb = o.pcb; i0_in = o.i0; i1_in = o.i1; r0_in = o.r0; r1_in = o.r1;
        addr_in = o.addr; md_in = o.wd;
        e.wea = o.pcb[0];
        e.web = o.pcb[1];
        e.i0  = o.i0;
        e.i1  = o.i1;
        e.r1  = o.r1;
        e.bf  = mr & o.pcb[4];
        e.bt  = e.bf ? o.rdata : 32'h0;
        e.r0  = (mr && !o.pcb[4]) ? o.rdata : o.r0;
        if (e.wea || e.web || e.bf) wbq.push_back(e);
        exp_n    = 0;
        rd_delay = mw ? o.d1 : o.d0;
        if (mw) begin
            busq.push_back('{1'b1, o.addr, o.wd, o.d0, 32'h0});
            exp_n += o.d0 + 1;
        end
        if (mr) begin
            busq.push_back('{1'b0, o.addr, 32'h0, rd_delay, o.rdata});
            exp_n += rd_delay + 1;
        end
        #1 chk("stall_capture", stall_o, mw | mr);
        @(negedge clk);
        nop();
        if (mw || mr) begin
            n = 0;
            while (stall_o && n < 100) begin
                n++;
                @(negedge clk);
            end
            chk("mem_latency", n, exp_n);
            chk("done_wb_en", {wea, web, bf}, {e.wea, e.web, e.bf});
            @(negedge clk);
            chk("after_done_wb_en", {wea, web, bf}, 0);
        end else begin
            chk("pass_wb_en", {wea, web, bf}, {e.wea, e.web, 1'b0});
            chk("pass_no_req", {stall_o, dmem_req_o}, 0);
        end
    endtask

    // Bus responder: serves queued transactions, checks request contents every cycle.
    initial begin
        bus_t cur;
        bit   in_txn;
        int   cnt;
        in_txn = 0;
        cnt = 0;
        dmem_ack_i = 1'b0;
        dmem_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (rst || !dmem_req_o) begin
                in_txn = 0;
                dmem_ack_i = 1'($urandom_range(0, 1));
                dmem_rdata_i = $urandom;
            end else begin
                if (!in_txn) begin
                    if (busq.size() == 0) begin
                        chk("bus_unexpected_req", 1, 0);
                        cur = '{dmem_we_o, dmem_addr_o, dmem_wdata_o, 0, 32'h0};
                    end else begin
                        cur = busq.pop_front();
                    end
                    in_txn = 1;
                    cnt = 0;
                end
                chk("bus_we", dmem_we_o, cur.we);
                chk("bus_addr", dmem_addr_o, cur.addr);
                if (cur.we) chk("bus_wdata", dmem_wdata_o, cur.wdata);
                chk("bus_stall", stall_o, 1);
                if (cnt == cur.delay) begin
                    dmem_ack_i = 1'b1;
                    dmem_rdata_i = cur.rdata;
                    in_txn = 0;
                end else begin
                    dmem_ack_i = 1'b0;
                    dmem_rdata_i = $urandom;
                    cnt++;
                end
            end
        end
    end

    // Writeback monitor: every visible writeback must match the next expected one.
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            if (!rst && (wea || web || bf)) begin
                if (wbq.size() == 0) begin
                    chk("wb_unexpected", {wea, web, bf}, 0);
                end else begin
                    e = wbq.pop_front();
                    chk("wb_en", {wea, web, bf}, {e.wea, e.web, e.bf});
                    chk("wb_idx", {i0_o, i1_o}, {e.i0, e.i1});
                    chk("wb_r0", r0_o, e.r0);
                    chk("wb_r1", r1_o, e.r1);
                    chk("wb_bt", bt, e.bt);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t o;
        rst = 1'b1;
        nop();
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        issue(mk(5'b00001, 32'h0, 32'h0, 4'd3, 32'h1234, 4'd0, 32'h0, 32'h0, 0, 0));
        issue(mk(5'b00101, 32'h100, 32'hCAFE, 4'd13, 32'h100, 4'd0, 32'h0, 32'h0, 2, 0));
        issue(mk(5'b01011, 32'h200, 32'h0, 4'd1, 32'h0, 4'd13, 32'h204, 32'hBEEF, 0, 0));
        issue(mk(5'b11000, 32'h300, 32'h0, 4'd2, 32'h55, 4'd4, 32'h66, 32'h1000, 1, 0));
        issue(mk(5'b01100, 32'h40, 32'h7777, 4'd5, 32'h8, 4'd6, 32'h9, 32'h4242, 1, 1));

        // Reset while a read waits for an ack that never comes.
        o = mk(5'b01001, 32'h500, 32'h0, 4'd7, 32'h11, 4'd8, 32'h22, 32'hDEAD, 1000, 0);
        pcb = o.pcb; i0_in = o.i0; i1_in = o.i1; r0_in = o.r0; r1_in = o.r1; addr_in = o.addr;
        busq.push_back('{1'b0, o.addr, 32'h0, 1000, o.rdata});
        @(negedge clk);
        nop();
        repeat (2) @(negedge clk);
        chk("pre_reset_req", {dmem_req_o, stall_o}, 2'b11);
        #2 rst = 1'b1;
        #1 check_zero("async_reset");
        @(negedge clk);
        rst = 1'b0;
        issue(mk(5'b00011, 32'h0, 32'h0, 4'd9, 32'hA5A5, 4'd10, 32'h5A5A, 32'h0, 0, 0));

        for (int k = 0; k < 150; k++) begin
            issue(mk(5'($urandom_range(0, 31)), $urandom, $urandom, 4'($urandom), $urandom,
                     4'($urandom), $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3)));
        end

        repeat (5) @(negedge clk);
        chk("wb_queue_empty", wbq.size(), 0);
        chk("bus_queue_empty", busq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_mem_stage.md
CPU_MEM_STAGE -- requirements
Module: cpu_mem_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, data-bus byte-address width.
REQ-002 SHALL have parameter PCB_W, default 5, pipeline-control-bit width; bit0 WA, bit1 WB, bit2 MW (memory write), bit3 MR (memory read), bit4 RET (read is a return-address fetch).
REQ-003 SHALL have one clock and an asynchronous, active-high reset. Ports: clk_i in 1, rising-edge clock; rst_i in 1, asynchronous active-high reset.
REQ-004 SHALL have these upstream inputs from execute: pipeline_control_bits_i in PCB_W; register0_write_index_i in 4; register1_write_index_i in 4; reg0_result_i in 32; reg1_result_i in 32; memory_address_i in ADDR_W; mem_result_i in 32 (store data).
REQ-005 SHALL have stall_o out 1, which holds the execute stage.
REQ-006 SHALL have these data-bus ports: dmem_req_o out 1; dmem_we_o out 1; dmem_addr_o out ADDR_W; dmem_wdata_o out 32; dmem_ack_i in 1; dmem_rdata_i in 32.
REQ-007 SHALL have these writeback outputs: register_wea_o out 1; register_web_o out 1; register0_write_index_o out 4; register1_write_index_o out 4; reg0_result_o out 32; reg1_result_o out 32.
REQ-008 SHALL have these branch outputs: branch_flag_o out 1; branch_target_o out 32 (return address loaded by RET).

Function
REQ-009 SHALL implement an FSM with states IDLE, WRITE, READ, DONE.
REQ-010 In IDLE with MW=MR=0, the stage SHALL register the inputs to the writeback outputs in 1 cycle, with wea/web taken from WA/WB, and stall_o=0.
REQ-011 In IDLE with MW or MR set, the stage SHALL capture all inputs, assert stall_o combinationally in the same cycle, and enter WRITE if MW else READ.
REQ-012 In WRITE, the stage SHALL drive dmem_req_o=1, dmem_we_o=1, dmem_addr_o=captured address, and dmem_wdata_o=captured mem_result; on dmem_ack_i it SHALL go to READ if MR is captured, else DONE.
REQ-013 In READ, the stage SHALL drive dmem_req_o=1, dmem_we_o=0, and the captured address; on dmem_ack_i it SHALL latch dmem_rdata_i and go to DONE.
REQ-014 Request outputs SHALL remain stable until ack; the stage SHALL NOT change address or data mid-transaction.
REQ-015 With MW and MR both set, the stage SHALL perform write then read on the same address, as two bus transactions.
REQ-016 In DONE, the stage SHALL present the writeback outputs for exactly 1 cycle, deassert stall_o, and return to IDLE.
REQ-017 Load data routing when MR=1 and RET=0: reg0_result_o SHALL equal the read data and reg1_result_o SHALL pass through unchanged (POP: loaded value to reg0, adjusted pointer to reg1).
REQ-018 RET=1 with MR=1: branch_flag_o SHALL be 1 for the DONE cycle and branch_target_o SHALL equal the read data; reg0_result_o SHALL be the captured reg0 value.
REQ-019 In all cycles other than the IDLE pass-through and DONE, register_wea_o and register_web_o SHALL be 0, so no double writeback occurs.
REQ-020 Pure-store ops (MW only) SHALL still write back reg0/reg1 per WA/WB in DONE (PUSH pointer update).
REQ-021 Minimum memory-op latency SHALL be capture + 1 bus cycle + DONE = 3 cycles when ack arrives in the first request cycle; an extra transaction SHALL add ≥1 cycle.
REQ-022 dmem_ack_i SHALL be ignored while dmem_req_o=0.
REQ-023 stall_o SHALL be 1 in every cycle the FSM is in WRITE or READ; inputs SHALL be sampled only in IDLE.

Reset
REQ-024 rst_i asserted SHALL immediately force IDLE and drive every output to 0: stall_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, wea, web, both indices, both results, branch_flag_o, and branch_target_o.
REQ-025 Reset mid-transaction SHALL abandon the bus request with no writeback; the first op after reset deassertion SHALL be sampled on the next rising edge.

Verification
REQ-026 ALU pass-through: PCB=00001, idx0=3, reg0=0x1234 -> next cycle wea=1, idx0=3, reg0_result=0x1234, stall_o=0, no dmem_req.
REQ-027 PUSH: PCB=00101, addr=0x100, wdata=0xCAFE, reg0=0x100, ack after 2 wait cycles -> req/we held 3 cycles at 0x100/0xCAFE, then wea=1 with reg0_result=0x100 for 1 cycle.
REQ-028 POP: PCB=01011, addr=0x200, reg1=0x204, rdata=0xBEEF, immediate ack -> reg0_result=0xBEEF, reg1_result=0x204, wea=web=1 in cycle 3.
REQ-029 RET: PCB=11000, addr=0x300, rdata=0x1000 -> branch_flag_o=1 and branch_target_o=0x1000 for exactly one cycle, wea=0.
REQ-030 MW+MR on 0x40 -> write transaction at 0x40 followed by read transaction at 0x40, stall_o continuous until DONE.
REQ-031 rst_i pulsed while in READ with no ack -> all outputs 0 asynchronously, req dropped, then a pass-through op completes normally.
